digit_serial_adder: RTL

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first. Each digit slice is a DIGIT-bit ripple of full adders, with the carry held in a register between cycles. The block sits in the arithmetic datapath where wide adds must trade latency for area, and is driven by a start/busy/done handshake.

---
 rtl/digit_serial_adder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock, LSB digit first.
// Optional signed-overflow output is built only when DSA_OVF_EN is defined.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef DSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [KW-1:0]    k_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;
    logic             last_s;
    logic [DIGIT-1:0] da_s;
    logic [DIGIT-1:0] db_s;
    logic [DIGIT:0]   rip_s;
`ifdef DSA_OVF_EN
    logic             ovf_r;
    logic             c_msb_s;
`endif

    // DIGIT-bit ripple of full adders; returns {carry_out, sum}.
    function automatic logic [DIGIT:0] ripple(input logic [DIGIT-1:0] x,
                                              input logic [DIGIT-1:0] y,
                                              input logic             ci);
        logic             c;
        logic [DIGIT-1:0] sum;
        c   = ci;
        sum = '0;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i] = x[i] ^ y[i] ^ c;
            c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, sum};
    endfunction

    assign accept_s = start && (state_r != RUN);
    assign last_s   = (k_r == KW'(N - 1));
    assign da_s     = a_r[int'(k_r) * DIGIT +: DIGIT];
    assign db_s     = b_r[int'(k_r) * DIGIT +: DIGIT];
    assign rip_s    = ripple(da_s, db_s, carry_r);
`ifdef DSA_OVF_EN
    // A sum bit is x^y^c_in, so the carry into the top bit can be recovered from it.
    assign c_msb_s  = rip_s[DIGIT-1] ^ da_s[DIGIT-1] ^ db_s[DIGIT-1];
`endif

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, operand capture, per-digit accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            s_r     <= '0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef DSA_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                a_r     <= a;
                b_r     <= sub ? ~b : b;
                carry_r <= sub ? 1'b1 : cin;
                k_r     <= '0;
                s_r     <= '0;
            end else if (state_r == RUN) begin
                s_r[int'(k_r) * DIGIT +: DIGIT] <= rip_s[DIGIT-1:0];
                carry_r <= rip_s[DIGIT];
                if (last_s) begin
                    k_r    <= '0;
                    cout_r <= rip_s[DIGIT];
`ifdef DSA_OVF_EN
                    ovf_r  <= c_msb_s ^ rip_s[DIGIT];
`endif
                end else begin
                    k_r <= k_r + KW'(1);
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
`ifdef DSA_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule
